// File: rtl/mult_arbiter.sv
//------------------------------------------------------------------------------
// Module  : mult_arbiter
// Brief   : Round-robin sharing of one pipelined signed 32x32->64 multiplier
//           between NUM_REQ requesters, with a per-operation watchdog.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module mult_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int TIMEOUT = 15
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_REQ-1:0]      req_valid,
    input  logic [32*NUM_REQ-1:0]   req_a,
    input  logic [32*NUM_REQ-1:0]   req_b,
    output logic [NUM_REQ-1:0]      req_ready,
    output logic [NUM_REQ-1:0]      resp_valid,
    output logic [63:0]             resp_y,
    output logic                    busy,
    output logic                    timeout_err,
    output logic [31:0]             mul_a,
    output logic [31:0]             mul_b,
    output logic                    mul_start,
    input  logic [63:0]             mul_y,
    input  logic                    mul_done
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = 8;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t             state;
    logic [IDX_W-1:0]   grant;
    logic [IDX_W-1:0]   last_grant;
    logic [CNT_W-1:0]   wait_cnt;

    logic               found;
    logic [IDX_W-1:0]   winner;
    int                 idx;

    // Rotating search starting just after the previous winner.
    always_comb begin
        found  = 1'b0;
        winner = last_grant;
        idx    = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = (int'(last_grant) + k) % NUM_REQ;
            if (!found && req_valid[idx]) begin
                found  = 1'b1;
                winner = IDX_W'(idx);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            grant       <= '0;
            last_grant  <= IDX_W'(NUM_REQ - 1);
            wait_cnt    <= '0;
            req_ready   <= '0;
            resp_valid  <= '0;
            resp_y      <= '0;
            busy        <= 1'b0;
            timeout_err <= 1'b0;
            mul_a       <= '0;
            mul_b       <= '0;
            mul_start   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (found) begin
                        mul_a      <= req_a[32*int'(winner) +: 32];
                        mul_b      <= req_b[32*int'(winner) +: 32];
                        grant      <= winner;
                        last_grant <= winner;
                        req_ready  <= NUM_REQ'(1) << winner;
                        mul_start  <= 1'b1;
                        busy       <= 1'b1;
                        state      <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    req_ready <= '0;
                    mul_start <= 1'b0;
                    wait_cnt  <= '0;
                    state     <= S_WAIT;
                end
                S_WAIT: begin
                    wait_cnt <= wait_cnt + CNT_W'(1);
                    // A done arriving on the last allowed cycle still wins.
                    if (mul_done) begin
                        resp_y     <= mul_y;
                        resp_valid <= NUM_REQ'(1) << grant;
                        state      <= S_RESP;
                    end else if (wait_cnt == CNT_W'(TIMEOUT - 1)) begin
                        resp_y      <= '0;
                        timeout_err <= 1'b1;
                        resp_valid  <= NUM_REQ'(1) << grant;
                        state       <= S_RESP;
                    end
                end
                S_RESP: begin
                    resp_valid <= '0;
                    busy       <= 1'b0;
                    state      <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mult_arbiter.sv
//------------------------------------------------------------------------------
// Module  : tb_mult_arbiter
// Brief   : Directed bench for mult_arbiter with a transaction-level model.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_mult_arbiter;

    localparam int NUM_REQ = 2;
    localparam int TIMEOUT = 15;

    logic                  clk = 1'b0;
    logic                  reset = 1'b1;
    logic [NUM_REQ-1:0]    req_valid = '0;
    logic [32*NUM_REQ-1:0] req_a = '0;
    logic [32*NUM_REQ-1:0] req_b = '0;
    logic [NUM_REQ-1:0]    req_ready;
    logic [NUM_REQ-1:0]    resp_valid;
    logic [63:0]           resp_y;
    logic                  busy;
    logic                  timeout_err;
    logic [31:0]           mul_a;
    logic [31:0]           mul_b;
    logic                  mul_start;
    logic [63:0]           mul_y = '0;
    logic                  mul_done = 1'b0;

    int errors = 0;
    int checks = 0;

    mult_arbiter #(.NUM_REQ(NUM_REQ), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_a(req_a),
        .req_b(req_b), .req_ready(req_ready), .resp_valid(resp_valid),
        .resp_y(resp_y), .busy(busy), .timeout_err(timeout_err),
        .mul_a(mul_a), .mul_b(mul_b), .mul_start(mul_start),
        .mul_y(mul_y), .mul_done(mul_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] prod(input logic [31:0] a, input logic [31:0] b);
        longint sa;
        longint sb;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        return 64'(sa * sb);
    endfunction

    // Multiplier model: latency mlat cycles, 0 means done never comes.
    int          mlat = 5;
    int          pend = 0;
    logic [63:0] mprod = '0;

    // Transaction model: offset t from the ISSUE cycle, resp at t == m_end.
    bit          m_known = 0;
    bit          m_active = 0;
    int          m_g = 0;
    int          m_t = 0;
    int          m_end = -1;
    int          m_last = NUM_REQ - 1;
    logic [31:0] m_a = '0;
    logic [31:0] m_b = '0;
    logic [63:0] m_resp_y = '0;
    logic        m_err = 1'b0;
    logic [NUM_REQ-1:0] e_ready, e_resp;

    always @(negedge clk) begin
        if (m_known) begin
            e_ready = (m_active && m_t == 0) ? NUM_REQ'(1) << m_g : '0;
            e_resp  = (m_active && m_t == m_end) ? NUM_REQ'(1) << m_g : '0;
            chk("req_ready", 64'(req_ready), 64'(e_ready));
            chk("mul_start", 64'(mul_start), 64'(e_ready != 0));
            chk("resp_valid", 64'(resp_valid), 64'(e_resp));
            chk("resp_y", resp_y, m_resp_y);
            chk("busy", 64'(busy), 64'(m_active));
            chk("timeout_err", 64'(timeout_err), 64'(m_err));
            chk("mul_a", 64'(mul_a), 64'(m_a));
            chk("mul_b", 64'(mul_b), 64'(m_b));
        end
        mul_done = 1'b0;
        mul_y    = 64'hBAD0_BAD0_BAD0_BAD0;
        if (pend > 0) begin
            pend--;
            if (pend == 0) begin
                mul_done = 1'b1;
                mul_y    = mprod;
            end
        end
        if (mul_start && mlat > 0) begin
            pend  = mlat;
            mprod = prod(mul_a, mul_b);
        end
        if (reset) begin
            m_known = 1; m_active = 0; m_last = NUM_REQ - 1;
            m_a = '0; m_b = '0; m_resp_y = '0; m_err = 1'b0;
        end else if (m_known) begin
            if (m_active) begin
                if (m_t == m_end) m_active = 0;
                else begin
                    if (m_t >= 1 && m_end < 0) begin
                        if (mul_done) begin
                            m_end = m_t + 1; m_resp_y = prod(m_a, m_b);
                        end else if (m_t == TIMEOUT) begin
                            m_end = m_t + 1; m_resp_y = '0; m_err = 1'b1;
                        end
                    end
                    m_t++;
                end
            end else if (req_valid != 0) begin
                for (int k = 1; k <= NUM_REQ; k++) begin
                    int i;
                    i = (m_last + k) % NUM_REQ;
                    if (!m_active && req_valid[i]) begin
                        m_active = 1; m_g = i; m_last = i; m_t = 0; m_end = -1;
                        m_a = req_a[32*i +: 32]; m_b = req_b[32*i +: 32];
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic v, input logic [31:0] a, input logic [31:0] b);
        req_valid[i]      = v;
        req_a[32*i +: 32] = a;
        req_b[32*i +: 32] = b;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic wait_ready(output int idx);
        idx = -1;
        for (int n = 0; n < 40 && idx < 0; n++) begin
            tick();
            if (req_ready != 0) idx = (req_ready == 2'b01) ? 0 : 1;
        end
        if (idx < 0) chk("ready_bound", 64'(req_ready), 64'(1));
    endtask

    task automatic wait_resp(output int n, output int idx);
        idx = -1;
        n   = 0;
        for (int c = 0; c < 40 && idx < 0; c++) begin
            tick();
            n++;
            if (resp_valid != 0) idx = (resp_valid == 2'b01) ? 0 : 1;
        end
        if (idx < 0) chk("resp_bound", 64'(resp_valid), 64'(1));
    endtask

    initial begin
        int g, n, r;
        int order[4];
        logic [63:0] exp_y[4];
        exp_y = '{64'd6, 64'd20, 64'd72, 64'hFFFF_FFFF_FFFF_FFD6};

        apply_reset();
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_resp_y", resp_y, 64'(0));

        // Single request, L=5.
        mlat = 5;
        set_req(0, 1'b1, 32'd6, 32'd7);
        wait_ready(g);
        chk("single_grant", 64'(g), 64'(0));
        chk("single_start", 64'(mul_start), 64'(1));
        set_req(0, 1'b0, 32'd0, 32'd0);
        wait_resp(n, r);
        chk("single_lat", 64'(n), 64'(6));
        chk("single_route", 64'(r), 64'(0));
        chk("single_y", resp_y, 64'd42);
        tick();
        chk("single_idle", 64'(busy), 64'(0));

        // Signed operands on requester 1.
        mlat = 3;
        set_req(1, 1'b1, 32'hFFFF_FFFD, 32'd7);
        wait_ready(g);
        chk("signed_grant", 64'(g), 64'(1));
        set_req(1, 1'b0, 32'd0, 32'd0);
        tick();
        chk("signed_mul_a", 64'(mul_a), 64'hFFFF_FFFD);
        chk("signed_mul_b", 64'(mul_b), 64'd7);
        wait_resp(n, r);
        chk("signed_route", 64'(r), 64'(1));
        chk("signed_y", resp_y, 64'hFFFF_FFFF_FFFF_FFEB);

        // Contention: both held, expect alternation starting at 0.
        apply_reset();
        mlat = 4;
        set_req(0, 1'b1, 32'd2, 32'd3);
        set_req(1, 1'b1, 32'd4, 32'd5);
        for (int t = 0; t < 4; t++) begin
            wait_ready(g);
            order[t] = g;
            if (t == 0) set_req(0, 1'b1, 32'd8, 32'd9);
            if (t == 1) set_req(1, 1'b1, 32'hFFFF_FFFA, 32'd7);
            if (t == 2) set_req(0, 1'b0, 32'd0, 32'd0);
            if (t == 3) set_req(1, 1'b0, 32'd0, 32'd0);
            wait_resp(n, r);
            chk("cont_grant", 64'(order[t]), 64'(t % 2));
            chk("cont_route", 64'(r), 64'(t % 2));
            chk("cont_y", resp_y, exp_y[t]);
        end

        // Timeout, then a good operation with the flag still set.
        mlat = 0;
        set_req(0, 1'b1, 32'd5, 32'd5);
        wait_ready(g);
        set_req(0, 1'b0, 32'd0, 32'd0);
        wait_resp(n, r);
        chk("to_lat", 64'(n), 64'(TIMEOUT + 1));
        chk("to_y", resp_y, 64'd0);
        chk("to_err", 64'(timeout_err), 64'(1));
        mlat = 2;
        set_req(1, 1'b1, 32'd10, 32'hFFFF_FFFF);
        wait_ready(g);
        set_req(1, 1'b0, 32'd0, 32'd0);
        wait_resp(n, r);
        chk("to_after_y", resp_y, 64'hFFFF_FFFF_FFFF_FFF6);
        chk("to_sticky", 64'(timeout_err), 64'(1));
        apply_reset();
        chk("to_cleared", 64'(timeout_err), 64'(0));

        // Reset two cycles after mul_start, late done must be ignored.
        mlat = 5;
        set_req(0, 1'b1, 32'd11, 32'd13);
        wait_ready(g);
        set_req(0, 1'b0, 32'd0, 32'd0);
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int c = 0; c < 8; c++) begin
            chk("rw_no_resp", 64'(resp_valid), 64'(0));
            tick();
        end
        chk("rw_busy", 64'(busy), 64'(0));
        chk("rw_mul_a", 64'(mul_a), 64'(0));
        chk("rw_resp_y", resp_y, 64'(0));
        set_req(0, 1'b1, 32'd1, 32'd1);
        set_req(1, 1'b1, 32'd2, 32'd2);
        wait_ready(g);
        chk("rw_first_grant", 64'(g), 64'(0));
        set_req(0, 1'b0, 32'd0, 32'd0);
        wait_resp(n, r);
        wait_ready(g);
        chk("rw_second_grant", 64'(g), 64'(1));
        set_req(1, 1'b0, 32'd0, 32'd0);
        wait_resp(n, r);
        chk("rw_second_y", resp_y, 64'd4);

        // Withdrawn request during WAIT.
        mlat = 6;
        set_req(0, 1'b1, 32'd7, 32'd8);
        wait_ready(g);
        set_req(0, 1'b0, 32'd0, 32'd0);
        tick();
        set_req(1, 1'b1, 32'd9, 32'd9);
        tick();
        tick();
        set_req(1, 1'b0, 32'd0, 32'd0);
        wait_resp(n, r);
        chk("wd_route", 64'(r), 64'(0));
        chk("wd_y", resp_y, 64'd56);
        for (int c = 0; c < 6; c++) begin
            tick();
            chk("wd_no_ready", 64'(req_ready), 64'(0));
        end

        tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule

`default_nettype wire

// File: doc/mult_arbiter.md
Name: mult_arbiter

Overview:
- Shares one pipelined signed 32x32->64 hardware multiplier between NUM_REQ requesters, e.g. the CPU multi-cycle ALU and a DMA/graphics helper.
- Grants requests round-robin and issues one multiply at a time.
- Holds the operands stable until the multiplier signals done, then routes the 64-bit product back to the granted requester.
- A watchdog prevents a requester from hanging if done never arrives.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- TIMEOUT, 15, cycles spent in WAIT without mul_done before aborting (1..255).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester request; held high until the matching req_ready bit is seen.
- req_a  in  32*NUM_REQ  packed signed operand A; requester i uses bits [32i+31:32i].
- req_b  in  32*NUM_REQ  packed signed operand B, same packing.
- req_ready  out  NUM_REQ  one-hot, one-cycle accept pulse.
- resp_valid  out  NUM_REQ  one-hot, one-cycle result pulse.
- resp_y  out  64  product for the requester flagged in resp_valid; holds its value between responses.
- busy  out  1  high in every state except IDLE.
- timeout_err  out  1  sticky error flag; cleared only by reset.
- mul_a  out  32  operand A to the multiplier.
- mul_b  out  32  operand B to the multiplier.
- mul_start  out  1  one-cycle start pulse to the multiplier.
- mul_y  in  64  product from the multiplier.
- mul_done  in  1  one-cycle completion pulse from the multiplier.

Behaviour:
- Clocking and reset:
  - Single clock; all state updates on posedge clk.
  - reset is synchronous and active-high.
- Reset values:
  - state=IDLE.
  - req_ready=0, resp_valid=0, mul_start=0, busy=0, timeout_err=0.
  - resp_y=0, mul_a=0, mul_b=0, wait counter=0.
  - last_grant=NUM_REQ-1, so requester 0 has first priority.
  - Reset mid-operation abandons the transaction: no response is issued, and any later mul_done is ignored because the state is IDLE.
- Arbitration:
  - Search starts at (last_grant+1) mod NUM_REQ and wraps.
  - The first requester with req_valid=1 wins and last_grant updates to it.
  - Ties are resolved purely by this rotation.
  - Requests are evaluated only in IDLE.
  - Dropping req_valid before req_ready is legal and withdraws the request.
- IDLE:
  - If any req_valid is high, latch the winner's operands into mul_a/mul_b, record the grant index, and go to ISSUE.
  - Otherwise stay in IDLE.
- ISSUE (exactly 1 cycle):
  - req_ready[g]=1 and mul_start=1.
  - Clear the wait counter; next state is WAIT.
  - The requester drops req_valid after seeing req_ready.
- WAIT:
  - mul_a/mul_b are held constant from ISSUE until leaving WAIT; mul_start=0.
  - The counter increments every cycle.
  - On mul_done=1: resp_y<=mul_y, go to RESP.
  - If the counter reaches TIMEOUT with mul_done=0: resp_y<=0, timeout_err<=1, go to RESP.
  - mul_done and the timeout in the same cycle: mul_done wins.
- RESP (exactly 1 cycle):
  - resp_valid[g]=1; next state is IDLE.
  - A new request may be granted in the following IDLE cycle.
- mul_done outside WAIT is ignored.
- Latency, with the ISSUE cycle as cycle 0 and multiplier done latency L:
  - mul_start is high in cycle 0.
  - mul_done arrives in cycle L.
  - resp_valid is high in cycle L+1.
  - Minimum request-to-request spacing is L+3 cycles (ISSUE + L in WAIT + RESP + IDLE).
- Products pass through unmodified; there is no sign or width conversion.
- resp_y and resp_valid change only on a RESP entry.

Test Plan:
- Single request: req0 with A=6, B=7; multiplier model with L=5 → req_ready[0] in cycle 0, mul_start pulse in cycle 0, resp_valid[0] in cycle 6 with resp_y=42, busy low afterwards.
- Signed operands: req1 with A=-3 (0xFFFFFFFD), B=7 → resp_y=0xFFFFFFFFFFFFFFEB on resp_valid[1]; mul_a/mul_b stable throughout WAIT.
- Contention: req0 and req1 both held continuously for 4 transactions → grant order 0,1,0,1; each response is routed to the correct requester with its own product (e.g. 2*3=6, 4*5=20).
- Timeout: model never asserts mul_done, TIMEOUT=15 → resp_valid pulse with resp_y=0, timeout_err=1 and it stays 1 through later successful operations until reset.
- Reset mid-WAIT: assert reset 2 cycles after mul_start, then deliver a late mul_done → no resp_valid, all outputs at reset values, next grant goes to requester 0.
- Withdrawn request: req1 raises and drops req_valid while a req0 transaction is in WAIT → only req0 is served; req1 never sees req_ready or resp_valid.
